screen_sequencer: RTL and testbench

//  Top-level screen controller for the VGA draw path. Chooses which full-screen image the draw

---
 rtl/screen_pkg.sv | 29 ++
 rtl/frame_edge_detect.sv | 24 ++
 rtl/screen_sequencer.sv | 166 ++++++++++++++++
 tb/tb_screen_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared types for the screen sequencer: image selection, sequencer states and fade limit.
package screen_pkg;

  typedef enum logic [1:0] {
    SCR_TITLE = 2'd0,
    SCR_PLAY  = 2'd1,
    SCR_OVER  = 2'd2
  } screen_e;

  typedef enum logic [2:0] {
    S_TITLE,
    S_PLAY,
    S_OVER,
    S_FADE_OUT,
    S_FADE_IN
  } seq_state_e;

  localparam logic [3:0] FADE_MAX = 4'd15;

  // Resting state reached once a fade-in towards the given screen completes.
  function automatic seq_state_e screen_to_state(screen_e scr);
    case (scr)
      SCR_PLAY: return S_PLAY;
      SCR_OVER: return S_OVER;
      default:  return S_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// One-cycle pulse on each falling edge of the active-low vsync; shared by per-frame blocks.
module frame_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic tick_o
);

  logic vsync_q;
  logic tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      tick_q  <= vsync_q & ~vsync_i;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/screen_sequencer.sv
// Screen/fade controller: picks the displayed image and brightness, stepping once per frame.
// Optional macro SCREEN_SEQ_TIMEOUT_EN adds an automatic return from game-over to title.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned FADE_FRAMES = 4,
  parameter int unsigned OVER_FRAMES = 180
) (
  input  logic       system_clock_in,
  input  logic       reset_n_in,
  input  logic       vsync,
  input  logic       start_btn,
  input  logic       player_dead,
  output screen_e    screen_sel,
  output logic [3:0] fade_level,
  output logic       game_enable,
  output logic       frame_tick
);

  localparam int unsigned CntW = $clog2(FADE_FRAMES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FADE_FRAMES - 1);

  seq_state_e      state_q, state_d;
  screen_e         target_q, target_d;
  screen_e         sel_q, sel_d;
  logic [3:0]      level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_evt_q, start_evt_d;
  logic            dead_evt_q, dead_evt_d;
  logic            start_btn_q;
  logic            ge_q, ge_d;
  logic            start_clr, dead_clr;

`ifdef SCREEN_SEQ_TIMEOUT_EN
  localparam int unsigned OverW = $clog2(OVER_FRAMES + 1);
  localparam logic [OverW-1:0] OverLast = OverW'(OVER_FRAMES - 1);
  logic [OverW-1:0] over_cnt_q, over_cnt_d;

  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) over_cnt_q <= '0;
    else             over_cnt_q <= over_cnt_d;
  end
`else
  // Game-over hold length only matters when the timeout is built.
  logic unused_over_frames;
  assign unused_over_frames = ^32'(OVER_FRAMES);
`endif

  frame_edge_detect u_frame_edge (
    .clk_i   (system_clock_in),
    .rst_ni  (reset_n_in),
    .vsync_i (vsync),
    .tick_o  (frame_tick)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sel_d     = sel_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    start_clr = 1'b0;
    dead_clr  = 1'b0;
`ifdef SCREEN_SEQ_TIMEOUT_EN
    over_cnt_d = over_cnt_q;
`endif
    if (frame_tick) begin
      case (state_q)
        S_TITLE: begin
          dead_clr = 1'b1;
          if (start_evt_q) begin
            start_clr = 1'b1;
            target_d  = SCR_PLAY;
            state_d   = S_FADE_OUT;
          end
        end
        S_PLAY: begin
          start_clr = 1'b1;
          if (dead_evt_q) begin
            dead_clr = 1'b1;
            target_d = SCR_OVER;
            state_d  = S_FADE_OUT;
          end
        end
        S_OVER: begin
          dead_clr = 1'b1;
          if (start_evt_q) begin
            start_clr = 1'b1;
            target_d  = SCR_TITLE;
            state_d   = S_FADE_OUT;
`ifdef SCREEN_SEQ_TIMEOUT_EN
          end else if (over_cnt_q == OverLast) begin
            target_d = SCR_TITLE;
            state_d  = S_FADE_OUT;
          end else begin
            over_cnt_d = over_cnt_q + 1'b1;
`endif
          end
        end
        S_FADE_OUT: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            // Image swap happens only while fully black.
            if (level_q == 4'd0) begin
              sel_d   = target_q;
              state_d = S_FADE_IN;
            end else begin
              level_d = level_q - 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FADE_IN: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (level_q == FADE_MAX) begin
              state_d = screen_to_state(target_q);
`ifdef SCREEN_SEQ_TIMEOUT_EN
              over_cnt_d = '0;
`endif
            end else begin
              level_d = level_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_TITLE;
      endcase
    end
    // A new event in the same cycle as a clear survives.
    start_evt_d = (start_btn & ~start_btn_q) | (start_evt_q & ~start_clr);
    dead_evt_d  = player_dead | (dead_evt_q & ~dead_clr);
    ge_d        = (state_d == S_PLAY);
  end

  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= S_TITLE;
      target_q    <= SCR_TITLE;
      sel_q       <= SCR_TITLE;
      level_q     <= FADE_MAX;
      cnt_q       <= '0;
      start_evt_q <= 1'b0;
      dead_evt_q  <= 1'b0;
      start_btn_q <= 1'b0;
      ge_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      sel_q       <= sel_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      start_evt_q <= start_evt_d;
      dead_evt_q  <= dead_evt_d;
      start_btn_q <= start_btn;
      ge_q        <= ge_d;
    end
  end

  assign screen_sel  = sel_q;
  assign fade_level  = level_q;
  assign game_enable = ge_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer; per-tick expectations queued and checked as frames pass.
module tb_screen_sequencer;
  import screen_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic       start_btn = 1'b0;
  logic       player_dead = 1'b0;
  screen_e    screen_sel;
  logic [3:0] fade_level;
  logic       game_enable;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [1:0] sel;
    logic [3:0] lvl;
    logic       ge;
  } exp_t;

  exp_t sb[$];

  screen_sequencer #(
    .FADE_FRAMES (2),
    .OVER_FRAMES (5)
  ) dut (
    .system_clock_in (clk),
    .reset_n_in      (rst_n),
    .vsync           (vsync),
    .start_btn       (start_btn),
    .player_dead     (player_dead),
    .screen_sel      (screen_sel),
    .fade_level      (fade_level),
    .game_enable     (game_enable),
    .frame_tick      (frame_tick)
  );

  always #5 clk = ~clk;

  // 20-cycle frame, vsync low for 2 cycles.
  initial begin
    forever begin
      repeat (18) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (2) @(posedge clk);
      #1 vsync = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Returns at the negedge where frame_tick is high; n = negedges waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    check("tick_seen", 32'(frame_tick), 32'd1);
  endtask

  // Expected outputs after tick k of a transition (k=0 is the tick that starts the fade).
  task automatic push_fade(input string tag, input int k0, input int k1,
                           input logic [1:0] from, input logic [1:0] to);
    exp_t e;
    for (int k = k0; k <= k1; k++) begin
      e.tag = $sformatf("%s_k%0d", tag, k);
      if (k < 32) begin
        e.sel = from;
        e.lvl = 4'(15 - k / 2);
      end else if (k < 64) begin
        e.sel = to;
        e.lvl = 4'((k - 32) / 2);
      end else begin
        e.sel = to;
        e.lvl = 4'd15;
      end
      e.ge = (k >= 64) && (to == 2'd1);
      sb.push_back(e);
    end
  endtask

  task automatic push_hold(input string tag, input int n, input logic [1:0] sel);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = $sformatf("%s_%0d", tag, i);
      e.sel = sel;
      e.lvl = 4'd15;
      e.ge  = (sel == 2'd1);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int   n;
    exp_t e;
    while (sb.size() > 0) begin
      wait_tick(n);
      @(negedge clk);
      e = sb.pop_front();
      check({e.tag, "_sel"}, 32'(screen_sel), 32'(e.sel));
      check({e.tag, "_lvl"}, 32'(fade_level), 32'(e.lvl));
      check({e.tag, "_ge"}, 32'(game_enable), 32'(e.ge));
    end
  endtask

  task automatic pulse(input bit is_start);
    @(negedge clk);
    @(negedge clk);
    if (is_start) start_btn = 1'b1;
    else          player_dead = 1'b1;
    @(negedge clk);
    start_btn   = 1'b0;
    player_dead = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(screen_sel), 32'd0);
    check("rst_lvl", 32'(fade_level), 32'd15);
    check("rst_ge", 32'(game_enable), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;

    // Frame tick placement and period
    @(negedge vsync);
    @(negedge clk);
    check("tick_before", 32'(frame_tick), 32'd0);
    @(negedge clk);
    check("tick_pulse", 32'(frame_tick), 32'd1);
    @(negedge clk);
    check("tick_single", 32'(frame_tick), 32'd0);
    wait_tick(n);
    wait_tick(n);
    check("tick_period", 32'(n), 32'd20);
    check("idle_title_sel", 32'(screen_sel), 32'd0);

    // Title -> play
    pulse(1'b1);
    push_fade("to_play", 0, 64, 2'd0, 2'd1);
    drain();

    // Play -> over, start pressed mid-fade is held and acts once over is reached
    pulse(1'b0);
    push_fade("to_over", 0, 10, 2'd1, 2'd2);
    drain();
    pulse(1'b1);
    push_fade("to_over", 11, 64, 2'd1, 2'd2);
    push_fade("held_to_title", 0, 64, 2'd2, 2'd0);
    drain();

    // Start press coincident with a tick: latch kept, fade begins on the next tick
    wait_tick(n);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    check("coinc_sel", 32'(screen_sel), 32'd0);
    check("coinc_lvl", 32'(fade_level), 32'd15);
    push_fade("coinc_to_play", 0, 64, 2'd0, 2'd1);
    drain();
    pulse(1'b0);
    push_fade("to_over2", 0, 64, 2'd1, 2'd2);
    drain();

    // Idle in game-over
`ifdef SCREEN_SEQ_TIMEOUT_EN
    push_hold("over_wait", 4, 2'd2);
    push_fade("timeout", 0, 16, 2'd2, 2'd0);
    drain();
`else
    push_hold("over_hold", 100, 2'd2);
    drain();
    pulse(1'b1);
    push_fade("over_exit", 0, 16, 2'd2, 2'd0);
    drain();
`endif

    // Asynchronous reset mid fade-out (level 7)
    check("pre_rst_lvl", 32'(fade_level), 32'd7);
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(screen_sel), 32'd0);
    check("async_rst_lvl", 32'(fade_level), 32'd15);
    check("async_rst_ge", 32'(game_enable), 32'd0);
    check("async_rst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
